// File: rtl/ddr_axi_bridge_if.sv
// AXI4 master port of the cache-to-DDR bridge (single-beat, 16-byte lines).
// The bridge drives the master modport; the MIG side drives the slave modport.
interface ddr_axi_bridge_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/ddr_axi_bridge.sv
// Cache line write-back / fill requests to single-beat AXI4 on the DDR2 MIG port.
// Optional macro DDR_RAW_ORDER_EN: hold off reads that hit the line of an in-flight write.
module ddr_axi_bridge #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    input  logic                i_rd_avalid,
    output logic                o_rd_aready,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_rd_valid,
    input  logic                i_rd_dready,
    ddr_axi_bridge_if.master    m_axi
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2, R_HOLD = 2'd3} r_state_t;

    w_state_t            r_w_state, w_w_state_nxt;
    logic                r_wr_ready, w_wr_ready_nxt;
    logic [ADDR_W-1:0]   r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid, w_wvalid_nxt;
    logic                r_aw_done, w_aw_done_nxt;
    logic                r_w_done, w_w_done_nxt;
    logic                r_bready, w_bready_nxt;

    r_state_t            r_r_state, w_r_state_nxt;
    logic                r_rd_aready, w_rd_aready_nxt;
    logic [ADDR_W-1:0]   r_araddr, w_araddr_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready, w_rready_nxt;
    logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
    logic                r_rd_valid, w_rd_valid_nxt;

    logic                w_raw_hit;
    logic                w_unused_resp;

    assign w_unused_resp = ^{m_axi.bresp, m_axi.rresp};

`ifdef DDR_RAW_ORDER_EN
    // Compared against the write engine's next state so the read is taken on the BRESP edge itself.
    assign w_raw_hit = i_rd_avalid && (w_w_state_nxt != W_IDLE) &&
                       (i_rd_addr[ADDR_W-1:4] == w_awaddr_nxt[ADDR_W-1:4]);
`else
    assign w_raw_hit = 1'b0;
`endif

    // Write engine next-state and next output values
    always_comb begin
        w_w_state_nxt  = r_w_state;
        w_wr_ready_nxt = r_wr_ready;
        w_awaddr_nxt   = r_awaddr;
        w_wdata_nxt    = r_wdata;
        w_awvalid_nxt  = r_awvalid;
        w_wvalid_nxt   = r_wvalid;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        w_bready_nxt   = r_bready;
        case (r_w_state)
            W_IDLE: begin
                w_wr_ready_nxt = 1'b1;
                if (i_wr_valid && r_wr_ready) begin
                    w_awaddr_nxt   = i_wr_addr;
                    w_wdata_nxt    = i_wr_data;
                    w_awvalid_nxt  = 1'b1;
                    w_wvalid_nxt   = 1'b1;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                    w_wr_ready_nxt = 1'b0;
                    w_w_state_nxt  = W_SEND;
                end else begin
                    w_w_state_nxt  = W_IDLE;
                end
            end
            W_SEND: begin
                w_aw_done_nxt = r_aw_done | (r_awvalid & m_axi.awready);
                w_w_done_nxt  = r_w_done  | (r_wvalid  & m_axi.wready);
                w_awvalid_nxt = r_awvalid & ~m_axi.awready;
                w_wvalid_nxt  = r_wvalid  & ~m_axi.wready;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_bready_nxt  = 1'b1;
                    w_w_state_nxt = W_RESP;
                end else begin
                    w_w_state_nxt = W_SEND;
                end
            end
            W_RESP: begin
                if (m_axi.bvalid && r_bready) begin
                    w_bready_nxt   = 1'b0;
                    w_wr_ready_nxt = 1'b1;
                    w_w_state_nxt  = W_IDLE;
                end else begin
                    w_w_state_nxt  = W_RESP;
                end
            end
            default: begin
                w_w_state_nxt  = W_IDLE;
                w_wr_ready_nxt = 1'b1;
                w_awvalid_nxt  = 1'b0;
                w_wvalid_nxt   = 1'b0;
                w_bready_nxt   = 1'b0;
            end
        endcase
    end

    // Read engine next-state and next output values
    always_comb begin
        w_r_state_nxt   = r_r_state;
        w_rd_aready_nxt = r_rd_aready;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rd_data_nxt   = r_rd_data;
        w_rd_valid_nxt  = r_rd_valid;
        case (r_r_state)
            R_IDLE: begin
                if (i_rd_avalid && !w_raw_hit) begin
                    w_araddr_nxt    = i_rd_addr;
                    w_arvalid_nxt   = 1'b1;
                    w_rd_aready_nxt = 1'b0;
                    w_r_state_nxt   = R_ADDR;
                end else begin
                    w_rd_aready_nxt = ~w_raw_hit;
                    w_r_state_nxt   = R_IDLE;
                end
            end
            R_ADDR: begin
                if (m_axi.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_r_state_nxt = R_DATA;
                end else begin
                    w_r_state_nxt = R_ADDR;
                end
            end
            R_DATA: begin
                // Every beat is captured so a non-last beat is simply overwritten by the last one.
                if (m_axi.rvalid && r_rready) begin
                    w_rd_data_nxt = m_axi.rdata;
                    if (m_axi.rlast) begin
                        w_rready_nxt   = 1'b0;
                        w_rd_valid_nxt = 1'b1;
                        w_r_state_nxt  = R_HOLD;
                    end else begin
                        w_r_state_nxt  = R_DATA;
                    end
                end else begin
                    w_r_state_nxt = R_DATA;
                end
            end
            R_HOLD: begin
                if (r_rd_valid && i_rd_dready) begin
                    w_rd_valid_nxt  = 1'b0;
                    w_rd_aready_nxt = 1'b1;
                    w_r_state_nxt   = R_IDLE;
                end else begin
                    w_r_state_nxt   = R_HOLD;
                end
            end
            default: begin
                w_r_state_nxt   = R_IDLE;
                w_rd_aready_nxt = 1'b1;
                w_arvalid_nxt   = 1'b0;
                w_rready_nxt    = 1'b0;
                w_rd_valid_nxt  = 1'b0;
            end
        endcase
    end

    // Write engine state and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_w_state  <= W_IDLE;
            r_wr_ready <= 1'b1;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            r_w_state  <= w_w_state_nxt;
            r_wr_ready <= w_wr_ready_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_wvalid   <= w_wvalid_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_bready   <= w_bready_nxt;
        end
    end

    // Read engine state and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_r_state   <= R_IDLE;
            r_rd_aready <= 1'b1;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_r_state   <= w_r_state_nxt;
            r_rd_aready <= w_rd_aready_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
        end
    end

    assign o_wr_ready  = r_wr_ready;
    assign o_rd_aready = r_rd_aready;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;

    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'b100;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'd0;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = {(DATA_W/8){1'b1}};
    assign m_axi.wlast   = r_wvalid;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = 3'b100;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 2'b00;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'd0;
    assign m_axi.arqos   = 4'd0;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;

endmodule

// File: tb/tb_ddr_axi_bridge.sv
// Directed self-checking bench for ddr_axi_bridge; the AXI slave is played step by step.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ddr_axi_bridge;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;

    logic                clk = 1'b0;
    logic                rst;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_avalid;
    logic                rd_aready;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                rd_dready;

    int checks = 0;
    int errors = 0;

    ddr_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    ddr_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_rd_addr   (rd_addr),
        .i_rd_avalid (rd_avalid),
        .o_rd_aready (rd_aready),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .i_rd_dready (rd_dready),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
        rd_addr = '0; rd_avalid = 1'b0; rd_dready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bresp = 2'b00; axi.bvalid = 1'b0;
        axi.arready = 1'b0;
        axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state and tie-offs
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_aready", rd_aready, 1'b1);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 128'd0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b00000);
        chk("rst_addrs", {axi.awaddr, axi.araddr}, 54'd0);
        chk("tie_aw", {axi.awlen, axi.awsize, axi.awburst, axi.awcache}, {8'd0, 3'b100, 2'b01, 4'b0011});
        chk("tie_ar", {axi.arlen, axi.arsize, axi.arburst, axi.arcache}, {8'd0, 3'b100, 2'b01, 4'b0011});
        chk("tie_wstrb", axi.wstrb, 16'hFFFF);

        // 1: write with always-ready slave
        axi.awready = 1'b1; axi.wready = 1'b1;
        wr_addr = 27'h0001230;
        wr_data = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("t1_aw_w_valid", {axi.awvalid, axi.wvalid, axi.wlast}, 3'b111);
        chk("t1_awaddr", axi.awaddr, 27'h0001230);
        chk("t1_wdata", axi.wdata, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
        chk("t1_wr_ready_lo", wr_ready, 1'b0);
        chk("t1_bready_lo", axi.bready, 1'b0);
        tick();
        chk("t1_valid_drop", {axi.awvalid, axi.wvalid}, 2'b00);
        chk("t1_bready_hi", axi.bready, 1'b1);
        chk("t1_wr_ready_busy", wr_ready, 1'b0);
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
        chk("t1_bready_drop", axi.bready, 1'b0);
        chk("t1_wr_ready_done", wr_ready, 1'b1);

        // 2: WREADY four cycles ahead of AWREADY, BVALID offered early
        axi.awready = 1'b0; axi.wready = 1'b0;
        wr_addr = 27'h0005670;
        wr_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("t2_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        axi.wready = 1'b1;
        tick();
        axi.wready = 1'b0;
        axi.bvalid = 1'b1;
        chk("t2_w_drop", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_aw_wait", {axi.awvalid, axi.wvalid, axi.bready, wr_ready}, 4'b1000);
        end
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        chk("t2_aw_drop", {axi.awvalid, axi.bready, wr_ready}, 3'b010);
        tick();
        axi.bvalid = 1'b0;
        chk("t2_done", {axi.awvalid, axi.wvalid, axi.bready, wr_ready}, 4'b0001);

        // 3: read with ARREADY delayed 2 cycles, slow consumer
        rd_addr = 27'h0004560;
        rd_avalid = 1'b1;
        tick();
        rd_avalid = 1'b0;
        chk("t3_arvalid", {axi.arvalid, rd_aready}, 2'b10);
        chk("t3_araddr", axi.araddr, 27'h0004560);
        tick();
        tick();
        chk("t3_ar_wait", {axi.arvalid, axi.rready}, 2'b10);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("t3_ar_drop", {axi.arvalid, axi.rready}, 2'b01);
        axi.rvalid = 1'b1; axi.rlast = 1'b1;
        axi.rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
        chk("t3_rd_valid", {rd_valid, axi.rready}, 2'b10);
        chk("t3_rd_data", rd_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", {rd_valid, rd_aready}, 2'b10);
            chk("t3_hold_data", rd_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        end
        rd_dready = 1'b1;
        tick();
        rd_dready = 1'b0;
        chk("t3_release", {rd_valid, rd_aready}, 2'b01);

        // 4: concurrent write (line 0x100) and read (line 0x200), B held off
        axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
        wr_addr = 27'h0001000; wr_data = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
        rd_addr = 27'h0002000;
        wr_valid = 1'b1; rd_avalid = 1'b1;
        tick();
        wr_valid = 1'b0; rd_avalid = 1'b0;
        chk("t4_both_valid", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b111);
        chk("t4_addrs", {axi.awaddr, axi.araddr}, {27'h0001000, 27'h0002000});
        tick();
        axi.arready = 1'b0;
        chk("t4_bready_rready", {axi.bready, axi.rready}, 2'b11);
        axi.rvalid = 1'b1; axi.rlast = 1'b0;
        axi.rdata = 128'h0000_0000_0000_0000_0000_0000_0000_0BAD;
        tick();
        chk("t4_nonlast_beat", {rd_valid, axi.rready}, 2'b01);
        axi.rlast = 1'b1;
        axi.rdata = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_0F0F_0F0F;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("t4_rd_valid", {rd_valid, axi.rready, axi.bready, wr_ready}, 4'b1010);
        chk("t4_rd_data_last", rd_data, 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_0F0F_0F0F);
        rd_dready = 1'b1;
        tick();
        rd_dready = 1'b0;
        chk("t4_read_done", {rd_valid, rd_aready, wr_ready}, 3'b010);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_b_wait", {axi.bready, wr_ready}, 2'b10);
        end
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
        chk("t4_write_done", {axi.bready, wr_ready}, 2'b01);

`ifdef DDR_RAW_ORDER_EN
        // 5: read of the in-flight write line waits for BRESP; a neighbouring line does not
        wr_addr = 27'h0003000; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        rd_addr = 27'h0003000; rd_avalid = 1'b1;
        tick();
        chk("t5_blocked", {axi.arvalid, rd_aready}, 2'b00);
        tick();
        chk("t5_still_blocked", {axi.arvalid, rd_aready}, 2'b00);
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0; rd_avalid = 1'b0;
        chk("t5_released", {axi.arvalid, wr_ready}, 2'b11);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 128'h33;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        rd_dready = 1'b1;
        tick();
        rd_dready = 1'b0;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        rd_addr = 27'h0003010; rd_avalid = 1'b1;
        tick();
        rd_avalid = 1'b0;
        chk("t5_other_line", axi.arvalid, 1'b1);
        axi.bvalid = 1'b1; axi.arready = 1'b1;
        tick();
        axi.bvalid = 1'b0; axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rlast = 1'b1;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        rd_dready = 1'b1;
        tick();
        rd_dready = 1'b0;
        chk("t5_idle", {wr_ready, rd_aready}, 2'b11);
`endif

        // 6: reset while write is in W_SEND and read is in R_DATA
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b1;
        wr_addr = 27'h0006660; wr_data = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        rd_addr = 27'h0009990;
        wr_valid = 1'b1; rd_avalid = 1'b1;
        tick();
        wr_valid = 1'b0; rd_avalid = 1'b0;
        tick();
        chk("t6_midop", {axi.awvalid, axi.wvalid, axi.rready, wr_ready, rd_aready}, 5'b11100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b00000);
        chk("t6_rst_ready", {wr_ready, rd_aready, rd_valid}, 3'b110);
        chk("t6_rst_data", {axi.awaddr, axi.araddr, axi.wdata}, 182'd0);

        axi.awready = 1'b1; axi.wready = 1'b1;
        wr_addr = 27'h0007770; wr_data = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
        rd_addr = 27'h0008880;
        wr_valid = 1'b1; rd_avalid = 1'b1;
        tick();
        wr_valid = 1'b0; rd_avalid = 1'b0;
        chk("t6_new_addrs", {axi.awaddr, axi.araddr}, {27'h0007770, 27'h0008880});
        tick();
        chk("t6_new_resp", {axi.bready, axi.rready}, 2'b11);
        axi.bvalid = 1'b1; axi.rvalid = 1'b1; axi.rlast = 1'b1;
        axi.rdata = 128'hC0DE_C0DE_C0DE_C0DE_C0DE_C0DE_C0DE_C0DE;
        tick();
        axi.bvalid = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("t6_new_done", {wr_ready, rd_valid}, 2'b11);
        chk("t6_new_data", rd_data, 128'hC0DE_C0DE_C0DE_C0DE_C0DE_C0DE_C0DE_C0DE);
        rd_dready = 1'b1;
        tick();
        rd_dready = 1'b0;
        chk("t6_new_release", {rd_valid, rd_aready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_axi_bridge.md
Name: ddr_axi_bridge

Overview:
- Downstream neighbour of the data-cache controller. Converts the cache's simple line-write and line-read request channels into single-beat AXI4 transactions on the 128-bit DDR2 MIG port.
- One 16-byte cache line per transaction.
- The write and read engines are independent FSMs and may be in flight simultaneously.

Parameters:
ADDR_W, 27, byte address width of cache-side and AXI addresses
DATA_W, 128, line/beat width in bits (WSTRB width = DATA_W/8)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wr_addr  input  ADDR_W  line address of write-back (low 4 bits zero)
wr_data  input  DATA_W  line data of write-back
wr_valid  input  1  write request valid
wr_ready  output  1  high = write engine idle; low from accept until BRESP received
rd_addr  input  ADDR_W  line address of fill
rd_avalid  input  1  read request valid
rd_aready  output  1  high = read engine idle
rd_data  output  DATA_W  registered fill line
rd_valid  output  1  fill line valid
rd_dready  input  1  cache accepts fill line
M_AXI_AW*  output  AXI4 write address channel: AWADDR[ADDR_W], AWVALID; ties AWLEN=0, AWSIZE=3'b100, AWBURST=2'b01, AWLOCK=0, AWCACHE=4'b0011, AWPROT=0, AWQOS=0
M_AXI_AWREADY  input  1
M_AXI_W*  output  AXI4 write data channel: WDATA[DATA_W], WSTRB all ones, WLAST=WVALID, WVALID
M_AXI_WREADY  input  1
M_AXI_BRESP  input  2  ignored
M_AXI_BVALID  input  1
M_AXI_BREADY  output  1
M_AXI_AR*  output  AXI4 read address channel: ARADDR[ADDR_W], ARVALID; ties ARLEN=0, ARSIZE=3'b100, ARBURST=2'b01, ARLOCK[2]=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0
M_AXI_ARREADY  input  1
M_AXI_RDATA  input  DATA_W
M_AXI_RRESP  input  2  ignored
M_AXI_RLAST  input  1
M_AXI_RVALID  input  1
M_AXI_RREADY  output  1

Behaviour:
Reset values (clocked on rst=1; also apply mid-transaction):
- wr_ready=1, rd_aready=1, rd_valid=0, rd_data=0.
- AWVALID=WVALID=BREADY=ARVALID=RREADY=0; AWADDR/ARADDR/WDATA=0.
- Both FSMs return to IDLE. Any outstanding AXI transaction is abandoned; the MIG is reset together with the core.

Write FSM (W_IDLE, W_SEND, W_RESP):
- W_IDLE: wr_ready=1. On wr_valid&&wr_ready, register wr_addr→AWADDR and wr_data→WDATA; next cycle AWVALID=WVALID=1, wr_ready=0, go to W_SEND.
- W_SEND: AW and W are tracked by separate done flags. AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY, in either order or together. When both flags are set, go to W_RESP with BREADY=1.
- W_RESP: on BVALID&&BREADY, BREADY=0, wr_ready=1 next cycle, go to W_IDLE.
- Minimum request-to-wr_ready-high latency with an always-ready slave: 3 cycles.
- wr_valid while wr_ready=0 is ignored; the cache polls for wr_ready going high as completion.

Read FSM (R_IDLE, R_ADDR, R_DATA, R_HOLD):
- R_IDLE: rd_aready=1. On rd_avalid&&rd_aready, register rd_addr→ARADDR, ARVALID=1, rd_aready=0, go to R_ADDR.
- R_ADDR: on ARREADY, ARVALID=0, RREADY=1, go to R_DATA.
- R_DATA: on RVALID&&RREADY&&RLAST, capture RDATA into rd_data, RREADY=0, rd_valid=1, go to R_HOLD. RVALID without RLAST is also captured, and the FSM stays in R_DATA; the last beat wins.
- R_HOLD: rd_data stable and rd_valid held until rd_valid&&rd_dready; then rd_valid=0 and rd_aready=1 next cycle, go to R_IDLE.
- rd_dready already high on entry completes the hold in one cycle.

General:
- The write and read FSMs never block each other (without the optional feature).
- Addresses pass through unmodified; low 4 bits are not checked.
- All outputs are registered; no combinational path from AXI inputs to cache-side outputs.

Optional Feature:
Macro DDR_RAW_ORDER_EN.
- Defined: in R_IDLE, a read request whose rd_addr[ADDR_W-1:4] equals the in-flight write line (write FSM not in W_IDLE) is not accepted. rd_aready is held 0 until the write's BRESP completes, which guarantees read-after-write ordering for the same line.
- Not defined: reads are accepted in R_IDLE regardless of write state.

Test Plan:
1. Write: wr_addr=27'h0001230, wr_data=128'hDEAD..., slave always ready → AWADDR=27'h0001230 and WDATA match; AWVALID/WVALID each high exactly 1 cycle; BREADY high until BVALID; wr_ready high 3 cycles after accept.
2. Split write handshake: WREADY 4 cycles before AWREADY → WVALID drops after its handshake; AWVALID stays high until AWREADY; B accepted only after both; single transaction.
3. Read: rd_addr=27'h0004560, ARREADY delayed 2 cycles, RDATA=128'h0123_4567_89AB_CDEF_... with RLAST → rd_valid=1 with exact data; rd_dready held 0 for 5 cycles → rd_valid and rd_data stable; released the cycle after rd_dready.
4. Concurrent: write to line 0x100 and read from line 0x200 issued in the same cycle → both AXI transactions proceed overlapped; without the macro, the read completes independently of B delay (BVALID held off 10 cycles).
5. DDR_RAW_ORDER_EN: write line 0x300 in flight, read line 0x300 requested → ARVALID stays 0 until the cycle after BVALID&&BREADY; a read of line 0x301 is accepted immediately.
6. Reset mid-op: assert rst during W_SEND and R_DATA → next cycle all VALIDs/READYs=0, wr_ready=1, rd_aready=1, rd_valid=0; a new request after reset completes normally.
